// File: rtl/multicycle_ctrl.sv
// Multicycle LEGv8 subset control unit: FETCH/DECODE/EXEC/MEM/WB sequencing
// with a bounded wait on data memory that parks in HALT on timeout.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [10:0] Instr,
    input  logic        zero_E,
    input  logic        mem_ready,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic        Reg2Loc,
    output logic        AluSrc,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic [3:0]  AluControl,
    output logic [3:0]  state_o,
    output logic        illegal,
    output logic        mem_err
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0, DECODE = 4'd1, EXEC_R = 4'd2, EXEC_M = 4'd3, MEM_RD = 4'd4,
        MEM_WR  = 4'd5, WB_R   = 4'd6, WB_M   = 4'd7, EXEC_CB = 4'd8, HALT = 4'd9
    } state_t;

    typedef enum logic [1:0] {CLS_R, CLS_LD, CLS_ST, CLS_CB} cls_t;

    localparam logic [7:0] TIMEOUT   = 8'(MEM_TIMEOUT);
    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    state_t     state_q, state_d;
    cls_t       cls_q, cls_d;
    logic [3:0] aluop_q, aluop_d;
    logic [7:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            cls_q   <= CLS_R;
            aluop_q <= 4'b0000;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            aluop_q <= aluop_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        aluop_d    = aluop_q;
        cnt_d      = cnt_q;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        PCSrc      = 1'b0;
        Reg2Loc    = 1'b0;
        AluSrc     = 1'b0;
        RegWrite   = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        MemtoReg   = 1'b0;
        AluControl = 4'b0000;
        illegal    = 1'b0;
        mem_err    = 1'b0;
        state_o    = state_q;

        case (state_q)
            FETCH: begin
                if (run) begin
                    IRWrite = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                casez (Instr)
                    11'b10001011000: begin cls_d = CLS_R;  aluop_d = ALU_ADD;   state_d = EXEC_R;  end
                    11'b11001011000: begin cls_d = CLS_R;  aluop_d = ALU_SUB;   state_d = EXEC_R;  end
                    11'b10001010000: begin cls_d = CLS_R;  aluop_d = ALU_AND;   state_d = EXEC_R;  end
                    11'b10101010000: begin cls_d = CLS_R;  aluop_d = ALU_ORR;   state_d = EXEC_R;  end
                    11'b11111000010: begin cls_d = CLS_LD; aluop_d = ALU_ADD;   state_d = EXEC_M;  end
                    11'b11111000000: begin cls_d = CLS_ST; aluop_d = ALU_ADD;   state_d = EXEC_M;  end
                    11'b10110100???: begin cls_d = CLS_CB; aluop_d = ALU_PASSB; state_d = EXEC_CB; end
                    default: begin
                        illegal = 1'b1;
                        PCWrite = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end
            EXEC_R: begin
                AluControl = aluop_q;
                state_d    = WB_R;
            end
            WB_R: begin
                AluControl = aluop_q;
                RegWrite   = 1'b1;
                PCWrite    = 1'b1;
                state_d    = FETCH;
            end
            EXEC_M: begin
                AluSrc     = 1'b1;
                AluControl = ALU_ADD;
                Reg2Loc    = (cls_q == CLS_ST);
                cnt_d      = 8'd0;
                state_d    = (cls_q == CLS_ST) ? MEM_WR : MEM_RD;
            end
            MEM_RD, MEM_WR: begin
                AluSrc     = 1'b1;
                AluControl = ALU_ADD;
                Reg2Loc    = (state_q == MEM_WR);
                MemRead    = (state_q == MEM_RD);
                MemWrite   = (state_q == MEM_WR);
                // A completion arriving on the last allowed cycle still wins over the timeout.
                if (mem_ready) begin
                    PCWrite = (state_q == MEM_WR);
                    state_d = (state_q == MEM_WR) ? FETCH : WB_M;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == TIMEOUT) state_d = HALT;
                end
            end
            WB_M: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                PCWrite  = 1'b1;
                state_d  = FETCH;
            end
            EXEC_CB: begin
                Reg2Loc    = 1'b1;
                AluControl = ALU_PASSB;
                PCWrite    = 1'b1;
                PCSrc      = zero_E;
                state_d    = FETCH;
            end
            HALT: begin
                mem_err = 1'b1;
            end
            default: state_d = FETCH;
        endcase

        // Outputs must be quiet for the whole time reset is held, not just after the next edge.
        if (reset) begin
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            PCSrc      = 1'b0;
            Reg2Loc    = 1'b0;
            AluSrc     = 1'b0;
            RegWrite   = 1'b0;
            MemRead    = 1'b0;
            MemWrite   = 1'b0;
            MemtoReg   = 1'b0;
            AluControl = 4'b0000;
            illegal    = 1'b0;
            mem_err    = 1'b0;
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: each instruction is expanded into its expected
// per-cycle output trace from the opcode table, then driven and compared.
module tb_multicycle_ctrl;
    localparam int TMO = 4;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100000;
    localparam int K_R = 0, K_LD = 1, K_ST = 2, K_CB = 3, K_ILL = 4;

    typedef struct packed {
        logic irw, pcw, pcsrc, r2l, alusrc, regw, memr, memw, m2r;
        logic [3:0] alu;
        logic [3:0] st;
        logic ill, merr;
    } out_t;

    typedef struct {
        logic        run;
        logic [10:0] instr;
        logic        zero;
        logic        rdy;
        out_t        e;
    } cyc_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic run = 1'b0;
    logic [10:0] Instr = '0;
    logic zero_E = 1'b0;
    logic mem_ready = 1'b0;
    logic IRWrite, PCWrite, PCSrc, Reg2Loc, AluSrc, RegWrite, MemRead, MemWrite, MemtoReg;
    logic [3:0] AluControl, state_o;
    logic illegal, mem_err;
    out_t act;
    cyc_t q[$];
    int nchk = 0;
    int nfail = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .run(run), .Instr(Instr), .zero_E(zero_E),
        .mem_ready(mem_ready), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
        .Reg2Loc(Reg2Loc), .AluSrc(AluSrc), .RegWrite(RegWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .AluControl(AluControl),
        .state_o(state_o), .illegal(illegal), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    assign act = {IRWrite, PCWrite, PCSrc, Reg2Loc, AluSrc, RegWrite, MemRead, MemWrite,
                  MemtoReg, AluControl, state_o, illegal, mem_err};

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic out_t o(input logic [3:0] st);
        out_t r;
        r = '0;
        r.st = st;
        return r;
    endfunction

    function automatic int kind_of(input logic [10:0] op);
        if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) return K_R;
        if (op == OP_LDUR) return K_LD;
        if (op == OP_STUR) return K_ST;
        if (op[10:3] == OP_CBZ[10:3]) return K_CB;
        return K_ILL;
    endfunction

    function automatic logic [3:0] alu_of(input logic [10:0] op);
        case (op)
            OP_AND:  return 4'b0000;
            OP_ORR:  return 4'b0001;
            OP_SUB:  return 4'b0110;
            default: return 4'b0010;
        endcase
    endfunction

    task automatic push(input logic r, input logic [10:0] i, input logic z, input logic rdy, input out_t e);
        cyc_t c;
        c.run = r; c.instr = i; c.zero = z; c.rdy = rdy; c.e = e;
        q.push_back(c);
    endtask

    task automatic push_idle();
        push(1'b0, 11'($urandom), rb(), rb(), o(4'd0));
    endtask

    // n = cycles spent in the memory state (ready on the last); n = 0 means memory never answers.
    task automatic add_instr(input logic [10:0] op, input int n, input logic z);
        out_t e;
        int k;
        int cnt;
        logic rdy;
        k = kind_of(op);
        e = o(4'd0); e.irw = 1'b1;
        push(1'b1, op, rb(), rb(), e);
        e = o(4'd1);
        if (k == K_ILL) begin e.ill = 1'b1; e.pcw = 1'b1; end
        push(rb(), op, rb(), rb(), e);
        if (k == K_R) begin
            e = o(4'd2); e.alu = alu_of(op);
            push(rb(), 11'($urandom), rb(), rb(), e);
            e.st = 4'd6; e.regw = 1'b1; e.pcw = 1'b1;
            push(rb(), 11'($urandom), rb(), rb(), e);
        end else if (k == K_CB) begin
            e = o(4'd8); e.r2l = 1'b1; e.alu = 4'b0111; e.pcw = 1'b1; e.pcsrc = z;
            push(rb(), 11'($urandom), z, rb(), e);
        end else if (k == K_LD || k == K_ST) begin
            e = o(4'd3); e.alusrc = 1'b1; e.alu = 4'b0010; e.r2l = (k == K_ST);
            push(rb(), 11'($urandom), rb(), rb(), e);
            cnt = (n == 0) ? TMO + 1 : n;
            for (int i = 0; i < cnt; i++) begin
                rdy = (n > 0) && (i == n - 1);
                e.st = (k == K_ST) ? 4'd5 : 4'd4;
                e.memr = (k == K_LD);
                e.memw = (k == K_ST);
                e.pcw = (k == K_ST) && rdy;
                push(rb(), 11'($urandom), rb(), rdy, e);
            end
            if (n == 0) begin
                for (int i = 0; i < 3; i++) begin
                    e = o(4'd9); e.merr = 1'b1;
                    push(rb(), 11'($urandom), rb(), rb(), e);
                end
            end else if (k == K_LD) begin
                e = o(4'd7); e.regw = 1'b1; e.m2r = 1'b1; e.pcw = 1'b1;
                push(rb(), 11'($urandom), rb(), rb(), e);
            end
        end
    endtask

    task automatic check(input string tag, input int idx, input out_t e);
        nchk++;
        if (act !== e) begin
            nfail++;
            $display("FAIL %s[%0d]: got %h (state %0d) expected %h (state %0d)",
                     tag, idx, act, act.st, e, e.st);
        end
    endtask

    // Entered and left 1 time unit after a rising edge.
    task automatic apply(input string tag, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            run = q[i].run; Instr = q[i].instr; zero_E = q[i].zero; mem_ready = q[i].rdy;
            @(negedge clk);
            check(tag, i, q[i].e);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1; run = 1'b1; Instr = OP_ADD; mem_ready = 1'b1; zero_E = 1'b1;
        @(negedge clk);
        check(tag, 0, o(4'd0));
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        out_t e;
        logic [10:0] op;
        #2 do_reset("reset");

        q.delete();
        push_idle(); push_idle();
        add_instr(OP_ADD, 0, 1'b0);
        add_instr(OP_SUB, 0, 1'b0);
        add_instr(OP_AND, 0, 1'b0);
        add_instr(OP_ORR, 0, 1'b0);
        add_instr(OP_LDUR, 3, 1'b0);
        add_instr(OP_STUR, 1, 1'b0);
        add_instr(OP_STUR, TMO + 1, 1'b0);
        add_instr(OP_LDUR, TMO + 1, 1'b0);
        add_instr(OP_CBZ, 0, 1'b1);
        add_instr(OP_CBZ | 11'd5, 0, 1'b0);
        add_instr(11'b00000000000, 0, 1'b0);
        push_idle(); push_idle();
        apply("directed", q.size());

        q.delete();
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 7))
                0: op = OP_ADD;
                1: op = OP_SUB;
                2: op = OP_AND;
                3: op = OP_ORR;
                4: op = OP_LDUR;
                5: op = OP_STUR;
                6: op = {OP_CBZ[10:3], 3'($urandom)};
                default: op = 11'($urandom);
            endcase
            if ($urandom_range(0, 3) == 0) push_idle();
            add_instr(op, $urandom_range(1, TMO + 1), rb());
        end
        apply("random", q.size());

        // Reset pulled in the middle of a load wait.
        q.delete();
        add_instr(OP_LDUR, TMO + 1, 1'b0);
        apply("ld_prefix", 4);
        run = 1'b0; mem_ready = 1'b0;
        e = o(4'd4); e.alusrc = 1'b1; e.alu = 4'b0010; e.memr = 1'b1;
        #1 check("mid_memrd", 0, e);
        reset = 1'b1;
        #1 check("reset_async", 0, o(4'd0));
        @(negedge clk);
        check("reset_hold", 0, o(4'd0));
        @(posedge clk);
        #1 reset = 1'b0; run = 1'b0;
        @(negedge clk);
        check("post_reset_idle", 0, o(4'd0));
        @(posedge clk);
        #1;

        // Store that never completes: HALT, then only reset recovers.
        q.delete();
        add_instr(OP_STUR, 0, 1'b0);
        apply("timeout", q.size());
        do_reset("halt_reset");
        q.delete();
        push_idle();
        add_instr(OP_ADD, 0, 1'b0);
        apply("after_halt", q.size());

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule
